// File: rtl/vcache_stat_collector_if.sv
// Purpose: dump-request handshake and dump word stream of the vcache statistics collector.
// Latency: wires only, no state.
// Backpressure: the request side waits on stat_req_ready_o; the stream side is held by withholding stat_yumi_i.
interface vcache_stat_collector_if #(
    parameter int ctr_width_p = 32,
    parameter int tag_width_p = 32
);
    logic                   stat_req_v_i;
    logic [tag_width_p-1:0] stat_req_tag_i;
    logic                   stat_req_ready_o;
    logic                   stat_v_o;
    logic [ctr_width_p-1:0] stat_data_o;
    logic                   stat_last_o;
    logic                   stat_yumi_i;

    // Collector side: accepts requests, produces words.
    modport slave (
        input  stat_req_v_i, stat_req_tag_i, stat_yumi_i,
        output stat_req_ready_o, stat_v_o, stat_data_o, stat_last_o
    );

    // Requester/consumer side: issues requests, consumes words.
    modport master (
        output stat_req_v_i, stat_req_tag_i, stat_yumi_i,
        input  stat_req_ready_o, stat_v_o, stat_data_o, stat_last_o
    );
endinterface

// File: rtl/vcache_stat_collector.sv
// Purpose: count vcache load/store/miss events (saturating) and dump a 6-word snapshot on request.
// Latency: word 0 valid the cycle after acceptance; 6 words back-to-back with yumi held, ready again in the 7th cycle.
// Backpressure: words hold steady until stat_yumi_i; no new request is accepted while a dump is in flight.
module vcache_stat_collector #(
    parameter int ctr_width_p = 32,
    parameter int tag_width_p = 32
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        inc_ld_i,
    input  logic        inc_st_i,
    input  logic        inc_ld_miss_i,
    input  logic        inc_st_miss_i,
    input  logic        clear_i,
    input  logic [31:0] global_ctr_i,
    vcache_stat_collector_if.slave stat_bus
);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                 state_r, state_n;
    logic [2:0]             idx_r, idx_n;
    logic                   accept;
    logic [3:0]             inc;
    logic [ctr_width_p-1:0] live_r [4];
    logic [ctr_width_p-1:0] snap_r [6];
    logic [ctr_width_p-1:0] word;

    // Counter slot order matches the dump order of words 2..5.
    assign inc = {inc_st_miss_i, inc_ld_miss_i, inc_st_i, inc_ld_i};

    // Live counters: clear beats any strobe, increments stop at all-ones.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 4; i++) live_r[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (clear_i)
                    live_r[i] <= '0;
                else if (inc[i] && (live_r[i] != '1))
                    live_r[i] <= live_r[i] + ctr_width_p'(1);
            end
        end
    end

    // Snapshot captures pre-increment counter values and is frozen for the whole dump.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 6; i++) snap_r[i] <= '0;
        end else if (accept) begin
            snap_r[0] <= ctr_width_p'(stat_bus.stat_req_tag_i);
            snap_r[1] <= ctr_width_p'(global_ctr_i);
            for (int i = 0; i < 4; i++) snap_r[i+2] <= live_r[i];
        end
    end

    // State and word index registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    // Next state: accept only in IDLE, so the final yumi cannot coincide with a new acceptance.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        accept  = 1'b0;
        case (state_r)
            IDLE: begin
                if (stat_bus.stat_req_v_i) begin
                    accept  = 1'b1;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (stat_bus.stat_yumi_i) begin
                    if (idx_r == 3'd5) begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx_r + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Word select from the frozen snapshot.
    always_comb begin
        word = '0;
        case (idx_r)
            3'd0:    word = snap_r[0];
            3'd1:    word = snap_r[1];
            3'd2:    word = snap_r[2];
            3'd3:    word = snap_r[3];
            3'd4:    word = snap_r[4];
            3'd5:    word = snap_r[5];
            default: word = '0;
        endcase
    end

    // Ready is masked by reset so it reads 0 while reset is held and IDLE is forced.
    assign stat_bus.stat_req_ready_o = reset_n_i && (state_r == IDLE);
    assign stat_bus.stat_v_o         = (state_r == SEND);
    assign stat_bus.stat_last_o      = (state_r == SEND) && (idx_r == 3'd5);
    assign stat_bus.stat_data_o      = word;

endmodule

// File: tb/tb_vcache_stat_collector.sv
module tb_vcache_stat_collector;

    logic        clk;
    logic        reset_n;
    logic        inc_ld, inc_st, inc_ld_miss, inc_st_miss, clear;
    logic [31:0] gctr;
    logic        inc_ld8, zero8;

    int checks   = 0;
    int failures = 0;

    vcache_stat_collector_if #(.ctr_width_p(32), .tag_width_p(32)) bus ();
    vcache_stat_collector_if #(.ctr_width_p(8),  .tag_width_p(8))  bus8 ();

    vcache_stat_collector #(.ctr_width_p(32), .tag_width_p(32)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .inc_ld_i     (inc_ld),
        .inc_st_i     (inc_st),
        .inc_ld_miss_i(inc_ld_miss),
        .inc_st_miss_i(inc_st_miss),
        .clear_i      (clear),
        .global_ctr_i (gctr),
        .stat_bus     (bus.slave)
    );

    vcache_stat_collector #(.ctr_width_p(8), .tag_width_p(8)) dut8 (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .inc_ld_i     (inc_ld8),
        .inc_st_i     (zero8),
        .inc_ld_miss_i(zero8),
        .inc_st_miss_i(zero8),
        .clear_i      (zero8),
        .global_ctr_i (gctr),
        .stat_bus     (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a dump and consume it with yumi held; optionally pulse all strobes in the acceptance cycle.
    task automatic dump(input logic [31:0] tag, input logic [31:0] gc,
                        input logic [31:0] w2, input logic [31:0] w3,
                        input logic [31:0] w4, input logic [31:0] w5,
                        input bit inc_all);
        logic [31:0] exp_w [6];
        exp_w[0] = tag; exp_w[1] = gc; exp_w[2] = w2;
        exp_w[3] = w3;  exp_w[4] = w4; exp_w[5] = w5;
        bus.stat_req_v_i   = 1'b1;
        bus.stat_req_tag_i = tag;
        gctr = gc;
        if (inc_all) begin
            inc_ld = 1'b1; inc_st = 1'b1; inc_ld_miss = 1'b1; inc_st_miss = 1'b1;
        end
        chk("req_ready_before", bus.stat_req_ready_o, 1);
        tick();
        bus.stat_req_v_i = 1'b0;
        inc_ld = 1'b0; inc_st = 1'b0; inc_ld_miss = 1'b0; inc_st_miss = 1'b0;
        bus.stat_yumi_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("word%0d_v", k), bus.stat_v_o, 1);
            chk($sformatf("word%0d_data", k), bus.stat_data_o, exp_w[k]);
            chk($sformatf("word%0d_last", k), bus.stat_last_o, (k == 5));
            chk($sformatf("word%0d_ready", k), bus.stat_req_ready_o, 0);
            tick();
        end
        bus.stat_yumi_i = 1'b0;
        chk("ready_after_dump", bus.stat_req_ready_o, 1);
        chk("v_after_dump", bus.stat_v_o, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        inc_ld = 0; inc_st = 0; inc_ld_miss = 0; inc_st_miss = 0; clear = 0;
        inc_ld8 = 0; zero8 = 0; gctr = 32'd0;
        bus.stat_req_v_i = 0; bus.stat_req_tag_i = '0; bus.stat_yumi_i = 0;
        bus8.stat_req_v_i = 0; bus8.stat_req_tag_i = '0; bus8.stat_yumi_i = 0;

        // Reset state, before any clock edge.
        #2;
        chk("rst_ready", bus.stat_req_ready_o, 0);
        chk("rst_v", bus.stat_v_o, 0);
        chk("rst_last", bus.stat_last_o, 0);
        chk("rst_data", bus.stat_data_o, 0);
        chk("rst8_ready", bus8.stat_req_ready_o, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", bus.stat_req_ready_o, 1);
        chk("v_after_rst", bus.stat_v_o, 0);

        // Basic counting and dump order.
        inc_ld = 1; repeat (10) tick(); inc_ld = 0;
        inc_st = 1; repeat (3) tick(); inc_st = 0;
        inc_ld_miss = 1; repeat (2) tick(); inc_ld_miss = 0;
        inc_st_miss = 1; tick(); inc_st_miss = 0;
        dump(32'hAB, 32'd500, 10, 3, 2, 1, 0);

        // All strobes during acceptance: snapshot is pre-increment.
        clear = 1; tick(); clear = 0;
        inc_ld = 1; inc_st = 1; inc_ld_miss = 1; inc_st_miss = 1;
        repeat (5) tick();
        inc_ld = 0; inc_st = 0; inc_ld_miss = 0; inc_st_miss = 0;
        dump(32'h11, 32'd600, 5, 5, 5, 5, 1);
        dump(32'h22, 32'd700, 6, 6, 6, 6, 0);

        // Clear wins over a simultaneous strobe.
        clear = 1; tick(); clear = 0;
        inc_st = 1; repeat (7) tick(); inc_st = 0;
        clear = 1; inc_st = 1; tick(); clear = 0; inc_st = 0;
        dump(32'h5A, 32'd650, 0, 0, 0, 0, 0);

        // Withheld yumi at index 2; live counters keep moving; second request held off.
        inc_ld = 1; repeat (4) tick(); inc_ld = 0;
        bus.stat_req_v_i = 1; bus.stat_req_tag_i = 32'h33; gctr = 32'd800;
        tick();
        bus.stat_req_v_i = 0;
        bus.stat_yumi_i = 1;
        chk("stall_w0", bus.stat_data_o, 32'h33); tick();
        chk("stall_w1", bus.stat_data_o, 32'd800); tick();
        bus.stat_yumi_i = 0;
        inc_ld = 1;
        bus.stat_req_v_i = 1; bus.stat_req_tag_i = 32'h44;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_data", k), bus.stat_data_o, 4);
            chk($sformatf("stall%0d_ready", k), bus.stat_req_ready_o, 0);
            chk($sformatf("stall%0d_v", k), bus.stat_v_o, 1);
            chk($sformatf("stall%0d_last", k), bus.stat_last_o, 0);
            tick();
        end
        inc_ld = 0;
        bus.stat_yumi_i = 1;
        chk("resume_w2", bus.stat_data_o, 4); tick();
        chk("resume_w3", bus.stat_data_o, 0); tick();
        chk("resume_w4", bus.stat_data_o, 0); tick();
        chk("resume_w5", bus.stat_data_o, 0);
        chk("resume_last", bus.stat_last_o, 1); tick();
        chk("second_not_taken_v", bus.stat_v_o, 0);
        chk("second_ready", bus.stat_req_ready_o, 1);
        tick();
        bus.stat_req_v_i = 0;
        chk("second_w0", bus.stat_data_o, 32'h44); tick();
        chk("second_w1", bus.stat_data_o, 32'd800); tick();
        chk("second_w2", bus.stat_data_o, 8); tick();
        tick(); tick();
        chk("second_last", bus.stat_last_o, 1); tick();
        bus.stat_yumi_i = 0;
        chk("second_done_ready", bus.stat_req_ready_o, 1);

        // Reset in the middle of a dump.
        inc_st = 1; repeat (2) tick(); inc_st = 0;
        bus.stat_req_v_i = 1; bus.stat_req_tag_i = 32'h55; gctr = 32'd900;
        tick();
        bus.stat_req_v_i = 0;
        bus.stat_yumi_i = 1;
        repeat (3) tick();
        bus.stat_yumi_i = 0;
        chk("mid_idx3_data", bus.stat_data_o, 2);
        chk("mid_idx3_v", bus.stat_v_o, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_v", bus.stat_v_o, 0);
        chk("async_rst_ready", bus.stat_req_ready_o, 0);
        chk("async_rst_data", bus.stat_data_o, 0);
        chk("async_rst_last", bus.stat_last_o, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst_ready", bus.stat_req_ready_o, 1);
        chk("post_rst_v", bus.stat_v_o, 0);
        dump(32'h66, 32'd900, 0, 0, 0, 0, 0);

        // 8-bit saturation and global counter truncation.
        inc_ld8 = 1; repeat (257) tick(); inc_ld8 = 0;
        bus8.stat_req_v_i = 1; bus8.stat_req_tag_i = 8'h07; gctr = 32'd500;
        tick();
        bus8.stat_req_v_i = 0;
        bus8.stat_yumi_i = 1;
        chk("sat_w0", bus8.stat_data_o, 8'h07); tick();
        chk("sat_w1_trunc", bus8.stat_data_o, 8'hF4); tick();
        chk("sat_ld", bus8.stat_data_o, 8'hFF); tick();
        chk("sat_st", bus8.stat_data_o, 0); tick();
        tick();
        chk("sat_last", bus8.stat_last_o, 1); tick();
        bus8.stat_yumi_i = 0;
        chk("sat_ready", bus8.stat_req_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
